// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Control bundle layout and FSM state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_BUSY = 2'd2
  } state_t;

  localparam int MC_CYCLES_DEF      = 4;
  localparam int BRANCH_PENALTY_DEF = 2;
  localparam int CNT_W              = 8;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic id_ex_re;
    logic if_id_fl;
    logic id_ex_fl;
    logic ex_mem_fl;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_we:     1'b1,
    if_id_we:  1'b1,
    id_ex_we:  1'b1,
    id_ex_re:  1'b1,
    if_id_fl:  1'b0,
    id_ex_fl:  1'b0,
    ex_mem_fl: 1'b0
  };

  localparam ctrl_t CTRL_RST = '{
    pc_we:     1'b0,
    if_id_we:  1'b0,
    id_ex_we:  1'b0,
    id_ex_re:  1'b0,
    if_id_fl:  1'b1,
    id_ex_fl:  1'b1,
    ex_mem_fl: 1'b1
  };

endpackage

// File: rtl/hazard_cycle_timer.sv
// Loadable down-counter shared by the FLUSH and MC_BUSY states.
// DONE marks the last cycle of the timed interval.
module hazard_cycle_timer
  import hazard_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] VALUE,
  output logic             DONE
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
    end else if (LOAD) begin
      cnt <= VALUE;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign DONE = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-buffer enable/flush control for the 16-bit core.
// Handles load-use stalls, taken-branch flushes and multicycle EX ops.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int BRANCH_PENALTY = BRANCH_PENALTY_DEF,
  parameter int MC_CYCLES      = MC_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ID_OP1_ADDRESS,
  input  logic [ADDR_W-1:0] ID_OP2_ADDRESS,
  input  logic              ID_USES_OP1,
  input  logic              ID_USES_OP2,
  input  logic              EX_MEM_READ,
  input  logic [ADDR_W-1:0] EX_DEST_ADDRESS,
  input  logic              EX_BRANCH_TAKEN,
  input  logic              EX_MULTI_START,
  output logic              PC_WRITE_ENABLE,
  output logic              IF_ID_WRITE_ENABLE,
  output logic              ID_EX_WRITE_ENABLE,
  output logic              ID_EX_READ_ENABLE,
  output logic              IF_ID_FLUSH,
  output logic              ID_EX_FLUSH,
  output logic              EX_MEM_FLUSH,
  output logic [WIDTH-1:0]  STALL_COUNT
);

  localparam logic [CNT_W-1:0] BP_LOAD = CNT_W'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic             match1;
  logic             match2;
  logic             load_use;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] stall_q;

  hazard_cycle_timer u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .LOAD  (tmr_load),
    .VALUE (tmr_value),
    .DONE  (tmr_done)
  );

  assign match1   = (ID_OP1_ADDRESS == EX_DEST_ADDRESS);
  assign match2   = (ID_OP2_ADDRESS == EX_DEST_ADDRESS);
  assign load_use = EX_MEM_READ
                  & (EX_DEST_ADDRESS != '0)
                  & ((ID_USES_OP1 & match1)
                   | (ID_USES_OP2 & match2));

  // State register; reset aborts any flush or multicycle interval.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and timer load; branch wins over multicycle start.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state)
      RUN: begin
        if (EX_BRANCH_TAKEN) begin
          if (BRANCH_PENALTY > 1) begin
            state_nxt = FLUSH;
            tmr_load  = 1'b1;
            tmr_value = BP_LOAD;
          end
        end else if (EX_MULTI_START) begin
          state_nxt = MC_BUSY;
          tmr_load  = 1'b1;
          tmr_value = MC_LOAD;
        end
      end
      FLUSH, MC_BUSY: begin
        if (tmr_done) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output decode; reset forces everything closed and flushing.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!RST) begin
      ctrl = CTRL_RST;
    end else begin
      unique case (state)
        RUN: begin
          unique case (1'b1)
            EX_BRANCH_TAKEN: begin
              ctrl.if_id_fl = 1'b1;
              ctrl.id_ex_fl = 1'b1;
            end
            (!EX_BRANCH_TAKEN && !EX_MULTI_START && load_use): begin
              ctrl.pc_we    = 1'b0;
              ctrl.if_id_we = 1'b0;
              ctrl.id_ex_fl = 1'b1;
            end
            default: ctrl = CTRL_RUN;
          endcase
        end
        FLUSH: begin
          ctrl.if_id_fl = 1'b1;
          ctrl.id_ex_fl = 1'b1;
        end
        MC_BUSY: begin
          ctrl.pc_we     = 1'b0;
          ctrl.if_id_we  = 1'b0;
          ctrl.id_ex_we  = 1'b0;
          ctrl.ex_mem_fl = 1'b1;
        end
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_q <= '0;
    end else if (!ctrl.pc_we && (stall_q != '1)) begin
      stall_q <= stall_q + WIDTH'(1);
    end
  end

  assign PC_WRITE_ENABLE    = ctrl.pc_we;
  assign IF_ID_WRITE_ENABLE = ctrl.if_id_we;
  assign ID_EX_WRITE_ENABLE = ctrl.id_ex_we;
  assign ID_EX_READ_ENABLE  = ctrl.id_ex_re;
  assign IF_ID_FLUSH        = ctrl.if_id_fl;
  assign ID_EX_FLUSH        = ctrl.id_ex_fl;
  assign EX_MEM_FLUSH       = ctrl.ex_mem_fl;
  assign STALL_COUNT        = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: cycle model plus directed vectors.
// Output vector order: pc,ifid_we,idex_we,idex_re,ifid_fl,idex_fl,exmem_fl.
module tb_pipeline_hazard_ctrl;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int BP     = 2;
  localparam int MC     = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [ADDR_W-1:0] ID_OP1_ADDRESS;
  logic [ADDR_W-1:0] ID_OP2_ADDRESS;
  logic              ID_USES_OP1;
  logic              ID_USES_OP2;
  logic              EX_MEM_READ;
  logic [ADDR_W-1:0] EX_DEST_ADDRESS;
  logic              EX_BRANCH_TAKEN;
  logic              EX_MULTI_START;
  logic              PC_WRITE_ENABLE;
  logic              IF_ID_WRITE_ENABLE;
  logic              ID_EX_WRITE_ENABLE;
  logic              ID_EX_READ_ENABLE;
  logic              IF_ID_FLUSH;
  logic              ID_EX_FLUSH;
  logic              EX_MEM_FLUSH;
  logic [WIDTH-1:0]  STALL_COUNT;

  pipeline_hazard_ctrl #(
    .WIDTH          (WIDTH),
    .ADDR_W         (ADDR_W),
    .BRANCH_PENALTY (BP),
    .MC_CYCLES      (MC)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .ID_OP1_ADDRESS     (ID_OP1_ADDRESS),
    .ID_OP2_ADDRESS     (ID_OP2_ADDRESS),
    .ID_USES_OP1        (ID_USES_OP1),
    .ID_USES_OP2        (ID_USES_OP2),
    .EX_MEM_READ        (EX_MEM_READ),
    .EX_DEST_ADDRESS    (EX_DEST_ADDRESS),
    .EX_BRANCH_TAKEN    (EX_BRANCH_TAKEN),
    .EX_MULTI_START     (EX_MULTI_START),
    .PC_WRITE_ENABLE    (PC_WRITE_ENABLE),
    .IF_ID_WRITE_ENABLE (IF_ID_WRITE_ENABLE),
    .ID_EX_WRITE_ENABLE (ID_EX_WRITE_ENABLE),
    .ID_EX_READ_ENABLE  (ID_EX_READ_ENABLE),
    .IF_ID_FLUSH        (IF_ID_FLUSH),
    .ID_EX_FLUSH        (ID_EX_FLUSH),
    .EX_MEM_FLUSH       (EX_MEM_FLUSH),
    .STALL_COUNT        (STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  int   m_flush  = 0;
  int   m_mc     = 0;
  int   m_stall  = 0;
  bit   chk_en   = 1'b0;
  logic [6:0] m_e;
  logic [6:0] dut_out;

  assign dut_out = {PC_WRITE_ENABLE, IF_ID_WRITE_ENABLE,
                    ID_EX_WRITE_ENABLE, ID_EX_READ_ENABLE,
                    IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH};

  function automatic logic [6:0] model_out();
    logic hz;
    if (!RST) return 7'b0000111;
    if (m_mc > 0) return 7'b0001001;
    if (m_flush > 0) return 7'b1111110;
    if (EX_BRANCH_TAKEN) return 7'b1111110;
    if (EX_MULTI_START) return 7'b1111000;
    hz = EX_MEM_READ && (EX_DEST_ADDRESS != 0) &&
         ((ID_USES_OP1 && ID_OP1_ADDRESS == EX_DEST_ADDRESS) ||
          (ID_USES_OP2 && ID_OP2_ADDRESS == EX_DEST_ADDRESS));
    return hz ? 7'b0011010 : 7'b1111000;
  endfunction

  always @(posedge CLK) begin
    m_e = model_out();
    if (!RST) begin
      m_flush = 0;
      m_mc    = 0;
      m_stall = 0;
    end else begin
      if (!m_e[6] && m_stall < 65535) m_stall++;
      if (m_mc > 0) m_mc--;
      else if (m_flush > 0) m_flush--;
      else if (EX_BRANCH_TAKEN) m_flush = BP - 1;
      else if (EX_MULTI_START) m_mc = MC - 1;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if (dut_out !== model_out()) begin
        failures++;
        $display("FAIL model_outputs t=%0t got=%b want=%b",
                 $time, dut_out, model_out());
      end
      checks++;
      if (STALL_COUNT !== WIDTH'(m_stall)) begin
        failures++;
        $display("FAIL model_stall t=%0t got=%0d want=%0d",
                 $time, STALL_COUNT, m_stall);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ID_OP1_ADDRESS  = '0;
    ID_OP2_ADDRESS  = '0;
    ID_USES_OP1     = 1'b0;
    ID_USES_OP2     = 1'b0;
    EX_MEM_READ     = 1'b0;
    EX_DEST_ADDRESS = '0;
    EX_BRANCH_TAKEN = 1'b0;
    EX_MULTI_START  = 1'b0;
  endtask

  task automatic set_lu();
    EX_MEM_READ     = 1'b1;
    EX_DEST_ADDRESS = 4'd3;
    ID_OP2_ADDRESS  = 4'd3;
    ID_USES_OP2     = 1'b1;
  endtask

  initial begin
    clr();
    RST = 1'b0;
    step();
    chk_en = 1'b1;
    #1 chk("rst_outs", 16'(dut_out), 16'h07);
    chk("rst_stall", STALL_COUNT, 16'h0);
    step();
    RST = 1'b1;
    #1 chk("run_outs", 16'(dut_out), 16'h78);
    chk("run_stall", STALL_COUNT, 16'h0);

    set_lu();
    #1 chk("lu_op2", 16'(dut_out), 16'h1A);
    step();
    clr();
    #1 chk("lu_after", 16'(dut_out), 16'h78);
    chk("lu_stall", STALL_COUNT, 16'h1);

    EX_MEM_READ = 1'b1;
    ID_USES_OP2 = 1'b1;
    #1 chk("lu_r0", 16'(dut_out), 16'h78);
    step();
    clr();

    EX_MEM_READ     = 1'b1;
    EX_DEST_ADDRESS = 4'd5;
    ID_OP1_ADDRESS  = 4'd5;
    ID_USES_OP1     = 1'b1;
    #1 chk("lu_op1", 16'(dut_out), 16'h1A);
    step();
    ID_USES_OP1 = 1'b0;
    #1 chk("lu_nouse", 16'(dut_out), 16'h78);
    step();
    clr();
    #1 chk("lu_stall2", STALL_COUNT, 16'h2);

    EX_BRANCH_TAKEN = 1'b1;
    #1 chk("br_c1", 16'(dut_out), 16'h7E);
    step();
    clr();
    set_lu();
    #1 chk("br_c2_lu", 16'(dut_out), 16'h7E);
    step();
    clr();
    #1 chk("br_done", 16'(dut_out), 16'h78);
    chk("br_stall", STALL_COUNT, 16'h2);

    EX_MULTI_START = 1'b1;
    #1 chk("mc_start", 16'(dut_out), 16'h78);
    step();
    clr();
    EX_BRANCH_TAKEN = 1'b1;
    #1 chk("mc_b1_br", 16'(dut_out), 16'h09);
    step();
    clr();
    #1 chk("mc_b2", 16'(dut_out), 16'h09);
    step();
    #1 chk("mc_b3", 16'(dut_out), 16'h09);
    step();
    #1 chk("mc_done", 16'(dut_out), 16'h78);
    chk("mc_stall", STALL_COUNT, 16'h5);

    EX_BRANCH_TAKEN = 1'b1;
    EX_MULTI_START  = 1'b1;
    set_lu();
    #1 chk("pri_c1", 16'(dut_out), 16'h7E);
    step();
    clr();
    #1 chk("pri_c2", 16'(dut_out), 16'h7E);
    step();
    #1 chk("pri_done", 16'(dut_out), 16'h78);
    chk("pri_stall", STALL_COUNT, 16'h5);

    EX_MULTI_START = 1'b1;
    step();
    clr();
    step();
    #1 chk("mcr_b2", 16'(dut_out), 16'h09);
    RST = 1'b0;
    step();
    RST = 1'b1;
    #1 chk("mcr_run", 16'(dut_out), 16'h78);
    chk("mcr_stall", STALL_COUNT, 16'h0);
    step();
    #1 chk("mcr_run2", 16'(dut_out), 16'h78);

    set_lu();
    repeat (65534) step();
    #1 chk("sat_fffe", STALL_COUNT, 16'hFFFE);
    repeat (3) step();
    #1 chk("sat_ffff", STALL_COUNT, 16'hFFFF);
    clr();
    step();
    #1 chk("sat_hold", STALL_COUNT, 16'hFFFF);
    RST = 1'b0;
    step();
    RST = 1'b1;
    #1 chk("sat_rst", STALL_COUNT, 16'h0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
